// File: rtl/dnn_pkg.sv
// rtl/dnn_pkg.sv - shared widths, head-fill select enum and wrap-increment helper for the sparse DNN datapath
package dnn_pkg;

    // Default field widths shared with the MAC array and the fetch stage.
    localparam int D_WIDTH_DEF = 16;
    localparam int I_WIDTH_DEF = 4;

    // Widest RAM pointer needed: DEPTH <= 1024 gives at most 1023 RAM entries.
    localparam int PTR_MAX_W = 10;

    // Source for the head (output) register on a given cycle.
    typedef enum logic [1:0] {
        HEAD_HOLD   = 2'd0,
        HEAD_BYPASS = 2'd1,
        HEAD_RAM    = 2'd2,
        HEAD_EMPTY  = 2'd3
    } head_sel_e;

    // Pointer increment that wraps from 'last' back to 0 by compare, so
    // RAM depths that are not powers of two work.
    function automatic logic [PTR_MAX_W-1:0] ptr_inc(
        input logic [PTR_MAX_W-1:0] ptr,
        input logic [PTR_MAX_W-1:0] last
    );
        return (ptr == last) ? '0 : ptr + 1'b1;
    endfunction

endpackage

// File: rtl/sparse_stream_fifo_if.sv
// rtl/sparse_stream_fifo_if.sv - handshake/status bundle between producer, FIFO and consumer
//
// Signals:
//   flush                                    synchronous clear request
//   in_valid / in_ready / in_data / in_index  producer side
//   out_valid / out_ready / out_data / out_index  consumer side
//   count, almost_full                       occupancy status
// Modports: slave = the FIFO, master = the environment driving it.
interface sparse_stream_fifo_if
    import dnn_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int I_WIDTH = I_WIDTH_DEF,
    parameter int DEPTH   = 16
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [D_WIDTH-1:0] in_data;
    logic [I_WIDTH-1:0] in_index;
    logic               out_valid;
    logic               out_ready;
    logic [D_WIDTH-1:0] out_data;
    logic [I_WIDTH-1:0] out_index;
    logic [CNT_W-1:0]   count;
    logic               almost_full;

    modport slave (
        input  flush, in_valid, in_data, in_index, out_ready,
        output in_ready, out_valid, out_data, out_index, count, almost_full
    );

    modport master (
        output flush, in_valid, in_data, in_index, out_ready,
        input  in_ready, out_valid, out_data, out_index, count, almost_full
    );

endinterface

// File: rtl/sparse_fifo_ram.sv
// rtl/sparse_fifo_ram.sv - simple dual-port RAM, synchronous write, asynchronous read
//
// Ports:
//   clk    in   write clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data (combinational from raddr)
// Kept as a separate block so a vendor RAM macro can be dropped in.
module sparse_fifo_ram #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 15,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sparse_stream_fifo.sv
// rtl/sparse_stream_fifo.sv - first-word-fall-through {data, index} FIFO with registered head, count and watermark
//
// Ports:
//   clk  in   clock, rising edge
//   rst  in   asynchronous active-low reset
//   bus  slave modport of sparse_stream_fifo_if (handshakes, flush, count, almost_full)
// Storage is the head register plus DEPTH-1 RAM entries; count covers both.
module sparse_stream_fifo
    import dnn_pkg::*;
#(
    parameter int D_WIDTH  = D_WIDTH_DEF,
    parameter int I_WIDTH  = I_WIDTH_DEF,
    parameter int DEPTH    = 16,
    parameter int AFULL_TH = DEPTH - 2
) (
    input  logic                 clk,
    input  logic                 rst,
    sparse_stream_fifo_if.slave  bus
);

    localparam int CNT_W    = $clog2(DEPTH + 1);
    localparam int RAM_D    = DEPTH - 1;
    localparam int PTR_W    = (RAM_D > 1) ? $clog2(RAM_D) : 1;
    localparam int E_WIDTH  = D_WIDTH + I_WIDTH;
    localparam logic [PTR_MAX_W-1:0] PTR_LAST = PTR_MAX_W'(RAM_D - 1);

    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr_inc;
    logic [PTR_W-1:0]   wr_ptr_inc;
    logic [E_WIDTH-1:0] ram_rdata;
    logic [CNT_W-1:0]   ram_cnt;
    logic [CNT_W-1:0]   count_next;
    logic               ram_empty;
    logic               push;
    logic               pop;
    logic               head_free;
    logic               ram_we;
    head_sel_e          head_sel;

    assign push      = bus.in_valid & bus.in_ready;
    assign pop       = bus.out_valid & bus.out_ready;
    assign head_free = ~bus.out_valid | pop;

    // Whatever is not in the head register lives in the RAM.
    assign ram_cnt   = bus.count - CNT_W'(bus.out_valid);
    assign ram_empty = (ram_cnt == '0);

    assign rd_ptr_inc = PTR_W'(ptr_inc(PTR_MAX_W'(rd_ptr), PTR_LAST));
    assign wr_ptr_inc = PTR_W'(ptr_inc(PTR_MAX_W'(wr_ptr), PTR_LAST));

    always_comb begin
        head_sel   = HEAD_HOLD;
        ram_we     = 1'b0;
        count_next = bus.count + CNT_W'(push) - CNT_W'(pop);
        if (bus.flush) begin
            head_sel   = HEAD_EMPTY;
            count_next = '0;
        end else begin
            if (pop && !ram_empty) begin
                head_sel = HEAD_RAM;
            end else if (push && head_free && ram_empty) begin
                // Empty (or emptying) FIFO: skip the RAM so latency stays at 1 cycle.
                head_sel = HEAD_BYPASS;
            end else if (pop) begin
                head_sel = HEAD_EMPTY;
            end
            ram_we = push && (head_sel != HEAD_BYPASS);
        end
    end

    sparse_fifo_ram #(
        .WIDTH (E_WIDTH),
        .DEPTH (RAM_D),
        .AW    (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata ({bus.in_data, bus.in_index}),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.in_ready    <= 1'b1;
            bus.out_valid   <= 1'b0;
            bus.out_data    <= '0;
            bus.out_index   <= '0;
            bus.count       <= '0;
            bus.almost_full <= (AFULL_TH == 0);
            rd_ptr          <= '0;
            wr_ptr          <= '0;
        end else begin
            bus.count       <= count_next;
            // Flags come from the next count so they stay registered yet exact.
            bus.in_ready    <= (count_next != CNT_W'(DEPTH));
            bus.almost_full <= (count_next >= CNT_W'(AFULL_TH));

            if (bus.flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (ram_we) begin
                    wr_ptr <= wr_ptr_inc;
                end
                if (head_sel == HEAD_RAM) begin
                    rd_ptr <= rd_ptr_inc;
                end
            end

            // Head data is left untouched on empty/flush; only out_valid drops.
            case (head_sel)
                HEAD_BYPASS: begin
                    bus.out_valid <= 1'b1;
                    bus.out_data  <= bus.in_data;
                    bus.out_index <= bus.in_index;
                end
                HEAD_RAM: begin
                    bus.out_valid <= 1'b1;
                    {bus.out_data, bus.out_index} <= ram_rdata;
                end
                HEAD_EMPTY: begin
                    bus.out_valid <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sparse_stream_fifo.sv
// tb/tb_sparse_stream_fifo.sv - directed self-checking bench for sparse_stream_fifo (DEPTH 5, AFULL_TH 3)
module tb_sparse_stream_fifo;

    localparam int D_WIDTH  = 16;
    localparam int I_WIDTH  = 4;
    localparam int DEPTH    = 5;
    localparam int AFULL_TH = 3;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    sparse_stream_fifo_if #(
        .D_WIDTH (D_WIDTH),
        .I_WIDTH (I_WIDTH),
        .DEPTH   (DEPTH)
    ) bus ();

    sparse_stream_fifo #(
        .D_WIDTH  (D_WIDTH),
        .I_WIDTH  (I_WIDTH),
        .DEPTH    (DEPTH),
        .AFULL_TH (AFULL_TH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] idx, input logic rdy);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_index  = idx;
        bus.out_ready = rdy;
    endtask

    initial begin
        rst       = 1'b0;
        bus.flush = 1'b0;
        drive(1'b0, 16'h0, 4'h0, 1'b0);
        step();
        step();
        rst = 1'b1;

        // Reset / idle
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_count", 32'(bus.count), 32'd0);
        check_eq("rst_out_data", 32'(bus.out_data), 32'd0);
        check_eq("rst_afull", 32'(bus.almost_full), 32'd0);

        // Fill to full with out_ready low
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 16'(i), 4'(i), 1'b0);
            step();
            check_eq($sformatf("fill_count_%0d", i), 32'(bus.count), 32'(i));
            check_eq($sformatf("fill_afull_%0d", i), 32'(bus.almost_full), (i >= 3) ? 32'd1 : 32'd0);
            check_eq($sformatf("fill_in_ready_%0d", i), 32'(bus.in_ready), (i < 5) ? 32'd1 : 32'd0);
            check_eq($sformatf("fill_head_%0d", i), 32'(bus.out_data), 32'h0001);
        end
        drive(1'b1, 16'h0006, 4'h6, 1'b0);
        step();
        check_eq("full_hold_count", 32'(bus.count), 32'd5);
        check_eq("full_hold_in_ready", 32'(bus.in_ready), 32'd0);

        // Drain in order
        drive(1'b0, 16'h0, 4'h0, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            check_eq($sformatf("drain_valid_%0d", k), 32'(bus.out_valid), 32'd1);
            check_eq($sformatf("drain_data_%0d", k), 32'(bus.out_data), 32'(k));
            check_eq($sformatf("drain_index_%0d", k), 32'(bus.out_index), 32'(k));
            step();
        end
        check_eq("drain_empty_valid", 32'(bus.out_valid), 32'd0);
        check_eq("drain_empty_count", 32'(bus.count), 32'd0);
        check_eq("drain_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("drain_afull", 32'(bus.almost_full), 32'd0);

        // Streaming at count 1 (bypass path)
        drive(1'b1, 16'h0100, 4'h0, 1'b1);
        step();
        check_eq("s1_first_data", 32'(bus.out_data), 32'h0100);
        check_eq("s1_first_count", 32'(bus.count), 32'd1);
        for (int j = 1; j < 20; j++) begin
            drive(1'b1, 16'h0100 + 16'(j), 4'(j), 1'b1);
            step();
            check_eq($sformatf("s1_data_%0d", j), 32'(bus.out_data), 32'h0100 + 32'(j));
            check_eq($sformatf("s1_index_%0d", j), 32'(bus.out_index), 32'(j % 16));
            check_eq($sformatf("s1_count_%0d", j), 32'(bus.count), 32'd1);
        end
        drive(1'b0, 16'h0, 4'h0, 1'b1);
        step();
        check_eq("s1_end_valid", 32'(bus.out_valid), 32'd0);
        check_eq("s1_end_count", 32'(bus.count), 32'd0);

        // Streaming at count 2 (RAM path, pointers wrap several times)
        drive(1'b1, 16'h0200, 4'h0, 1'b0);
        step();
        drive(1'b1, 16'h0201, 4'h1, 1'b0);
        step();
        for (int j = 2; j < 12; j++) begin
            drive(1'b1, 16'h0200 + 16'(j), 4'(j), 1'b1);
            step();
            check_eq($sformatf("s2_data_%0d", j), 32'(bus.out_data), 32'h0200 + 32'(j - 1));
            check_eq($sformatf("s2_index_%0d", j), 32'(bus.out_index), 32'(j - 1));
            check_eq($sformatf("s2_count_%0d", j), 32'(bus.count), 32'd2);
        end
        drive(1'b0, 16'h0, 4'h0, 1'b1);
        step();
        check_eq("s2_tail_data", 32'(bus.out_data), 32'h020B);
        check_eq("s2_tail_count", 32'(bus.count), 32'd1);
        step();
        check_eq("s2_end_valid", 32'(bus.out_valid), 32'd0);

        // Flush with simultaneous push and pop at count 3
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 16'h0300 + 16'(i), 4'(i), 1'b0);
            step();
        end
        check_eq("pre_flush_count", 32'(bus.count), 32'd3);
        drive(1'b1, 16'h0304, 4'h4, 1'b1);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check_eq("flush_count", 32'(bus.count), 32'd0);
        check_eq("flush_valid", 32'(bus.out_valid), 32'd0);
        check_eq("flush_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("flush_afull", 32'(bus.almost_full), 32'd0);
        check_eq("flush_head_kept", 32'(bus.out_data), 32'h0301);
        drive(1'b0, 16'h0, 4'h0, 1'b1);
        step();
        check_eq("post_flush_valid", 32'(bus.out_valid), 32'd0);
        check_eq("post_flush_count", 32'(bus.count), 32'd0);
        drive(1'b1, 16'h0305, 4'h5, 1'b0);
        step();
        check_eq("post_flush_data", 32'(bus.out_data), 32'h0305);
        check_eq("post_flush_count1", 32'(bus.count), 32'd1);
        drive(1'b0, 16'h0, 4'h0, 1'b1);
        step();
        check_eq("post_flush_drained", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset between edges mid-burst
        drive(1'b1, 16'h0401, 4'h1, 1'b0);
        step();
        drive(1'b1, 16'h0402, 4'h2, 1'b0);
        step();
        drive(1'b1, 16'h0403, 4'h3, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_valid", 32'(bus.out_valid), 32'd0);
        check_eq("arst_count", 32'(bus.count), 32'd0);
        check_eq("arst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("arst_out_data", 32'(bus.out_data), 32'd0);
        check_eq("arst_afull", 32'(bus.almost_full), 32'd0);
        drive(1'b0, 16'h0, 4'h0, 1'b0);
        step();
        rst = 1'b1;
        drive(1'b1, 16'h04AA, 4'hA, 1'b0);
        step();
        drive(1'b0, 16'h0, 4'h0, 1'b0);
        check_eq("arst_next_data", 32'(bus.out_data), 32'h04AA);
        check_eq("arst_next_index", 32'(bus.out_index), 32'hA);
        check_eq("arst_next_count", 32'(bus.count), 32'd1);
        step();
        check_eq("arst_alone_count", 32'(bus.count), 32'd1);
        drive(1'b0, 16'h0, 4'h0, 1'b1);
        step();
        check_eq("arst_alone_valid", 32'(bus.out_valid), 32'd0);
        check_eq("arst_alone_count0", 32'(bus.count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
